// File: rtl/ranging_pkg.sv
// Shared definitions for the ultrasonic ranging sequencer: FSM state encoding,
// default timing constants and a small state helper.
package ranging_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        DONE      = 3'd4,
        HOLDOFF   = 3'd5
    } state_e;

    localparam int DEF_TICK_DIV      = 2941;
    localparam int DEF_TRIG_CYCLES   = 1000;
    localparam int DEF_PERIOD_CYCLES = 6_000_000;
    localparam int DEF_TIMEOUT_TICKS = 1200;
    localparam int DEF_CNT_W         = 12;

    function automatic logic state_is_busy(input state_e st);
        return (st != IDLE);
    endfunction

endpackage

// File: rtl/ranging_sequencer_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV cycles;
// a clear restarts the count and suppresses a tick due in the same cycle.
module tick_prescaler #(
    parameter int TICK_DIV = 2941
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear has priority over the natural wrap
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
        tick = (cnt_q == LAST) && !clear;
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ranging_sequencer.sv
// One-at-a-time ultrasonic ranging: pulses the trigger, times the echo-high width
// in measurement ticks and reports half of it as the distance in cm.
module ranging_sequencer
    import ranging_pkg::*;
#(
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             system_clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic             cathode,
    output logic             stimulus,
    output logic [CNT_W-1:0] distance_cm,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    // Longest possible cycle: trigger, full wait, full measure, plus slack.
    localparam int PER_MAX = PERIOD_CYCLES + TRIG_CYCLES + 2 * TIMEOUT_TICKS * TICK_DIV + 4;
    localparam int PER_W   = $clog2(PER_MAX);

    localparam logic [PER_W-1:0] TRIG_LAST   = PER_W'(TRIG_CYCLES - 1);
    localparam logic [PER_W-1:0] PERIOD_LAST = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_ONE     = PER_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e             state_q;
    state_e             state_d;
    logic [PER_W-1:0]   period_q;
    logic [PER_W-1:0]   period_d;
    logic [CNT_W-1:0]   tick_cnt_q;
    logic [CNT_W-1:0]   tick_cnt_d;
    logic [CNT_W-1:0]   tick_next;
    logic               aborted_q;
    logic               aborted_d;
    logic [2:0]         echo_pipe_q;
    logic [2:0]         echo_pipe_d;
    logic               stimulus_q;
    logic               stimulus_d;
    logic [CNT_W-1:0]   distance_q;
    logic [CNT_W-1:0]   distance_d;
    logic               meas_valid_q;
    logic               meas_valid_d;
    logic               timeout_q;
    logic               timeout_d;
    logic               busy_q;
    logic               busy_d;

    logic               presc_clear;
    logic               tick;
    logic               rise;
    logic               fall;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (system_clk),
        .rst_n (reset),
        .clear (presc_clear),
        .tick  (tick)
    );

    // Bits [1:0] synchronise the echo; bit 2 is the delayed copy for edge detection
    always_comb begin
        echo_pipe_d = {echo_pipe_q[1:0], cathode};
        rise        = echo_pipe_q[1] & ~echo_pipe_q[2];
        fall        = ~echo_pipe_q[1] & echo_pipe_q[2];
    end

    // Next-state, counter and output computation
    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        tick_cnt_d  = tick_cnt_q;
        aborted_d   = aborted_q;
        presc_clear = 1'b0;
        tick_next   = (tick_cnt_q == '1) ? tick_cnt_q : tick_cnt_q + CNT_ONE;

        case (state_q)
            IDLE: begin
                if (run_en) begin
                    state_d = TRIG;
                end else begin
                    state_d = IDLE;
                end
            end
            TRIG: begin
                if (period_q == TRIG_LAST) begin
                    state_d     = WAIT_ECHO;
                    presc_clear = 1'b1;
                    tick_cnt_d  = '0;
                end else begin
                    state_d = TRIG;
                end
            end
            WAIT_ECHO: begin
                if (rise) begin
                    state_d     = MEASURE;
                    presc_clear = 1'b1;
                    tick_cnt_d  = '0;
                end else if (tick) begin
                    tick_cnt_d = tick_next;
                    if (tick_next >= TIMEOUT_C) begin
                        state_d   = DONE;
                        aborted_d = 1'b1;
                    end else begin
                        state_d = WAIT_ECHO;
                    end
                end else begin
                    state_d = WAIT_ECHO;
                end
            end
            MEASURE: begin
                // A tick coinciding with the fall is still counted
                if (tick) begin
                    tick_cnt_d = tick_next;
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
                if (fall) begin
                    state_d   = DONE;
                    aborted_d = 1'b0;
                end else if (tick && (tick_next >= TIMEOUT_C)) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = MEASURE;
                end
            end
            DONE: begin
                state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (period_q >= PERIOD_LAST) begin
                    if (run_en) begin
                        state_d = TRIG;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HOLDOFF;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d == TRIG) && (state_q != TRIG)) begin
            period_d = '0;
        end else if ((state_q != IDLE) && (period_q != '1)) begin
            period_d = period_q + PER_ONE;
        end else begin
            period_d = period_q;
        end

        stimulus_d   = (state_q == TRIG);
        busy_d       = state_is_busy(state_d);
        meas_valid_d = (state_q == DONE);
        if (state_q == DONE) begin
            timeout_d = aborted_q;
            if (aborted_q) begin
                distance_d = distance_q;
            end else begin
                distance_d = tick_cnt_q >> 1;
            end
        end else begin
            timeout_d  = timeout_q;
            distance_d = distance_q;
        end
    end

    // State, counters, echo pipeline and registered outputs
    always_ff @(posedge system_clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            period_q     <= '0;
            tick_cnt_q   <= '0;
            aborted_q    <= 1'b0;
            echo_pipe_q  <= 3'b000;
            stimulus_q   <= 1'b0;
            distance_q   <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            tick_cnt_q   <= tick_cnt_d;
            aborted_q    <= aborted_d;
            echo_pipe_q  <= echo_pipe_d;
            stimulus_q   <= stimulus_d;
            distance_q   <= distance_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign stimulus    = stimulus_q;
    assign distance_cm = distance_q;
    assign meas_valid  = meas_valid_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ranging_sequencer.sv
// Self-checking bench for ranging_sequencer with shortened timing constants:
// vector table, hand-written corner sequences and randomized echo widths.
module tb_ranging_sequencer;

    localparam int TB_TICK_DIV = 10;
    localparam int TB_TRIG     = 5;
    localparam int TB_PERIOD   = 2000;
    localparam int TB_TIMEOUT  = 100;
    localparam int TB_CNT_W    = 12;

    logic                system_clk = 1'b0;
    logic                reset      = 1'b0;
    logic                run_en     = 1'b0;
    logic                cathode    = 1'b0;
    logic                stimulus;
    logic [TB_CNT_W-1:0] distance_cm;
    logic                meas_valid;
    logic                timeout;
    logic                busy;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int mv_count = 0;
    int last_rise = 0;
    int prev_rise = 0;
    logic stim_d  = 1'b0;
    int last_fall_cyc = 0;
    int last_mv_cyc   = 0;
    int model_prev    = 0;

    typedef struct {
        int dly;
        int wid;
        int exp_d;
        bit exp_t;
    } vec_t;

    vec_t tbl[9];

    ranging_sequencer #(
        .TICK_DIV      (TB_TICK_DIV),
        .TRIG_CYCLES   (TB_TRIG),
        .PERIOD_CYCLES (TB_PERIOD),
        .TIMEOUT_TICKS (TB_TIMEOUT),
        .CNT_W         (TB_CNT_W)
    ) dut (
        .system_clk  (system_clk),
        .reset       (reset),
        .run_en      (run_en),
        .cathode     (cathode),
        .stimulus    (stimulus),
        .distance_cm (distance_cm),
        .meas_valid  (meas_valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #5 system_clk = ~system_clk;

    always @(posedge system_clk) cyc <= cyc + 1;

    // Passive monitor: meas_valid pulses and trigger rising edges
    always @(negedge system_clk) begin
        stim_d <= stimulus;
        if (meas_valid) mv_count <= mv_count + 1;
        if (stimulus && !stim_d) begin
            prev_rise <= last_rise;
            last_rise <= cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge system_clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_stim(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (stimulus === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge system_clk);
        end
    endtask

    task automatic wait_mv(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge system_clk);
            if (meas_valid === 1'b1) begin
                ok = 1'b1;
                last_mv_cyc = cyc;
                break;
            end
        end
    endtask

    // Reference: whole ticks inside the echo width, halved; abort at the tick limit
    task automatic model_result(input int wid, output int d, output bit t);
        int ticks;
        ticks = wid / TB_TICK_DIV;
        if (wid == 0 || ticks >= TB_TIMEOUT) begin
            d = model_prev;
            t = 1'b1;
        end else begin
            d = ticks / 2;
            t = 1'b0;
        end
        model_prev = d;
    endtask

    task automatic run_meas(input string nm, input int dly, input int wid,
                            input int exp_d, input bit exp_t);
        bit ok;
        bit ok_mv;
        wait_stim(1'b1, 2600, ok);
        check({nm, "_trig_seen"}, 32'(ok), 32'd1);
        wait_stim(1'b0, 20, ok);
        check({nm, "_trig_end"}, 32'(ok), 32'd1);
        last_fall_cyc = cyc;
        fork
            begin
                step(dly);
                if (wid > 0) begin
                    cathode = 1'b1;
                    step(wid);
                    cathode = 1'b0;
                end
            end
            begin
                wait_mv(3000, ok_mv);
                check({nm, "_valid_seen"}, 32'(ok_mv), 32'd1);
                check({nm, "_distance"}, 32'(distance_cm), 32'(exp_d));
                check({nm, "_timeout"}, 32'(timeout), 32'(exp_t));
                step(1);
                check({nm, "_valid_width"}, 32'(meas_valid), 32'd0);
            end
        join
    endtask

    initial begin
        bit ok;
        int hi;
        int bhi;
        int mvc0;
        int lat;
        int rd;
        int rw;
        int ed;
        bit et;

        tbl[0] = '{dly: 10, wid: 400,  exp_d: 20, exp_t: 1'b0};
        tbl[1] = '{dly: 10, wid: 409,  exp_d: 20, exp_t: 1'b0};
        tbl[2] = '{dly: 10, wid: 410,  exp_d: 20, exp_t: 1'b0};
        tbl[3] = '{dly: 10, wid: 420,  exp_d: 21, exp_t: 1'b0};
        tbl[4] = '{dly: 10, wid: 19,   exp_d: 0,  exp_t: 1'b0};
        tbl[5] = '{dly: 10, wid: 20,   exp_d: 1,  exp_t: 1'b0};
        tbl[6] = '{dly: 5,  wid: 999,  exp_d: 49, exp_t: 1'b0};
        tbl[7] = '{dly: 5,  wid: 1200, exp_d: 49, exp_t: 1'b1};
        tbl[8] = '{dly: 0,  wid: 0,    exp_d: 49, exp_t: 1'b1};

        // Test 1: reset with run_en high, then the trigger pulse
        reset   = 1'b0;
        run_en  = 1'b1;
        cathode = 1'b0;
        step(10);
        check("rst_stimulus", 32'(stimulus), 32'd0);
        check("rst_distance", 32'(distance_cm), 32'd0);
        check("rst_valid", 32'(meas_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        step(1);
        check("t1_stim_delay", 32'(stimulus), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        step(1);
        check("t1_stim_start", 32'(stimulus), 32'd1);
        hi = 0;
        while (stimulus === 1'b1 && hi < 20) begin
            hi++;
            step(1);
        end
        check("t1_stim_width", 32'(hi), 32'(TB_TRIG));

        // Test 2: 400-cycle echo gives 40 ticks, 20 cm
        step(2);
        cathode = 1'b1;
        step(400);
        cathode = 1'b0;
        wait_mv(3000, ok);
        check("t2_valid_seen", 32'(ok), 32'd1);
        check("t2_distance", 32'(distance_cm), 32'd20);
        check("t2_timeout", 32'(timeout), 32'd0);
        step(1);
        check("t2_valid_width", 32'(meas_valid), 32'd0);
        model_prev = 20;

        // Test 3: no echo at all
        run_meas("t3", 0, 0, 20, 1'b1);
        lat = last_mv_cyc - last_fall_cyc;
        check("t3_wait_latency_ok", 32'((lat >= 998) && (lat <= 1002)), 32'd1);

        // Test 4: long echo overruns the period; retrigger follows DONE directly
        wait_stim(1'b1, 2600, ok);
        check("t4_trig_seen", 32'(ok), 32'd1);
        wait_stim(1'b0, 20, ok);
        check("t4_trig_end", 32'(ok), 32'd1);
        fork
            begin
                step(992);
                cathode = 1'b1;
                step(1500);
                cathode = 1'b0;
            end
            begin
                bit okm;
                wait_mv(3000, okm);
                check("t4_valid_seen", 32'(okm), 32'd1);
                check("t4_timeout", 32'(timeout), 32'd1);
                check("t4_distance", 32'(distance_cm), 32'd20);
                step(1);
                check("t4_stim_pre", 32'(stimulus), 32'd0);
                step(1);
                check("t4_retrigger", 32'(stimulus), 32'd1);
            end
        join
        // Echo still high on WAIT_ECHO entry: no clean rise, so it aborts
        wait_mv(2500, ok);
        check("t4_high_entry_seen", 32'(ok), 32'd1);
        check("t4_high_entry_timeout", 32'(timeout), 32'd1);
        check("t4_high_entry_dist", 32'(distance_cm), 32'd20);

        // Test 5: late reflection in HOLDOFF is ignored; period is exact
        run_meas("t5", 10, 200, 10, 1'b0);
        step(200);
        cathode = 1'b1;
        step(50);
        cathode = 1'b0;
        mvc0 = mv_count;
        wait_stim(1'b1, 2600, ok);
        check("t5_trig_seen", 32'(ok), 32'd1);
        step(1);
        check("t5_holdoff_ignored", 32'(mv_count - mvc0), 32'd0);
        check("t5_period", 32'(last_rise - prev_rise), 32'(TB_PERIOD));
        model_prev = 10;

        // Vector table
        for (int i = 0; i < 9; i++) begin
            run_meas($sformatf("tbl%0d", i), tbl[i].dly, tbl[i].wid, tbl[i].exp_d, tbl[i].exp_t);
        end
        model_prev = tbl[8].exp_d;

        // Randomized echo widths against the reference model
        for (int i = 0; i < 5; i++) begin
            rd = int'($urandom_range(1, 300));
            rw = int'($urandom_range(2, 980));
            model_result(rw, ed, et);
            run_meas($sformatf("rnd%0d_w%0d", i, rw), rd, rw, ed, et);
        end

        // Test 6: drop run_en mid-measure; the cycle completes then idles
        wait_stim(1'b1, 2600, ok);
        check("t6_trig_seen", 32'(ok), 32'd1);
        wait_stim(1'b0, 20, ok);
        step(10);
        cathode = 1'b1;
        step(100);
        run_en = 1'b0;
        step(200);
        cathode = 1'b0;
        wait_mv(3000, ok);
        check("t6_valid_seen", 32'(ok), 32'd1);
        check("t6_distance", 32'(distance_cm), 32'd15);
        check("t6_timeout", 32'(timeout), 32'd0);
        hi = 0;
        while (busy === 1'b1 && hi < 2200) begin
            hi++;
            step(1);
        end
        check("t6_goes_idle", 32'(busy), 32'd0);
        hi  = 0;
        bhi = 0;
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if (stimulus !== 1'b0) hi++;
            if (busy !== 1'b0) bhi++;
        end
        check("t6_idle_no_stim", 32'(hi), 32'd0);
        check("t6_idle_not_busy", 32'(bhi), 32'd0);

        // Reset pulse during MEASURE aborts with no report
        run_en = 1'b1;
        wait_stim(1'b1, 10, ok);
        check("t6b_trig_seen", 32'(ok), 32'd1);
        wait_stim(1'b0, 20, ok);
        step(10);
        cathode = 1'b1;
        step(100);
        reset  = 1'b0;
        run_en = 1'b0;
        step(1);
        check("t6b_rst_busy", 32'(busy), 32'd0);
        check("t6b_rst_stim", 32'(stimulus), 32'd0);
        check("t6b_rst_distance", 32'(distance_cm), 32'd0);
        check("t6b_rst_timeout", 32'(timeout), 32'd0);
        check("t6b_rst_valid", 32'(meas_valid), 32'd0);
        reset   = 1'b1;
        cathode = 1'b0;
        mvc0 = mv_count;
        bhi  = 0;
        for (int i = 0; i < 1500; i++) begin
            step(1);
            if (busy !== 1'b0) bhi++;
        end
        check("t6b_no_valid", 32'(mv_count - mvc0), 32'd0);
        check("t6b_stays_idle", 32'(bhi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
